// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that shares one combinational 8-bit logic unit among NREQ requesters.
// Grants in IDLE, drives the unit for one EXEC cycle, then returns the result tagged with its ID.
module logic_unit_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_op,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        lu_a,
    output logic [7:0]        lu_b,
    output logic [2:0]        lu_s,
    input  logic [7:0]        lu_o,
    output logic              done,
    output logic [7:0]        result,
    output logic [IDW-1:0]    done_id,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);

    typedef enum logic {StIdle, StExec} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, grant_q, grant_d, ptr_next;
    logic            found;
    logic [NREQ-1:0] ack_sel;
    logic [7:0]      sel_a, sel_b;
    logic [2:0]      sel_op;
    logic [7:0]      lu_a_q, lu_b_q, result_q;
    logic [2:0]      lu_s_q;
    logic            done_q;
    logic [IDW-1:0]  done_id_q;
    logic [CNTW-1:0] op_count_q;

    // Two passes: requesters at or above ptr first, then the ones below it.
    always_comb begin
        found   = 1'b0;
        grant_d = '0;
        ack_sel = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_op  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i] && i >= int'(ptr_q)) begin
                found      = 1'b1;
                grant_d    = IDW'(i);
                ack_sel[i] = 1'b1;
                sel_a      = req_a[8*i +: 8];
                sel_b      = req_b[8*i +: 8];
                sel_op     = req_op[3*i +: 3];
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i] && i < int'(ptr_q)) begin
                found      = 1'b1;
                grant_d    = IDW'(i);
                ack_sel[i] = 1'b1;
                sel_a      = req_a[8*i +: 8];
                sel_b      = req_b[8*i +: 8];
                sel_op     = req_op[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StExec;
            StExec:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ptr_next = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            lu_a_q     <= '0;
            lu_b_q     <= '0;
            lu_s_q     <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StExec);
            if (state_q == StIdle && found) begin
                lu_a_q  <= sel_a;
                lu_b_q  <= sel_b;
                lu_s_q  <= sel_op;
                grant_q <= grant_d;
            end
            if (state_q == StExec) begin
                result_q   <= lu_o;
                done_id_q  <= grant_q;
                op_count_q <= op_count_q + 1'b1;
                ptr_q      <= ptr_next;
            end
        end
    end

    // ack is combinational, so it must be masked while reset is held.
    assign ack      = (state_q == StIdle && !rst) ? ack_sel : '0;
    assign lu_a     = lu_a_q;
    assign lu_b     = lu_b_q;
    assign lu_s     = lu_s_q;
    assign done     = done_q;
    assign result   = result_q;
    assign done_id  = done_id_q;
    assign busy     = (state_q != StIdle);
    assign op_count = op_count_q;

endmodule
